// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline
// writeback and a long-latency MDU. MDU results that lose arbitration are
// queued; a starvation counter or a full queue forces a one-cycle StallWB
// so the queue head can write. The rd values held in the queue are exported
// as a mask for the hazard unit.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_rd_i,
  input  logic [31:0] mdu_data_i,
  output logic        mdu_ready_o,
  output logic        RegWriteRF,
  output logic [4:0]  RdRF,
  output logic [31:0] WDRF,
  output logic        StallWB,
  output logic [31:0] pending_mask_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(STARVE_LIMIT);

  typedef enum logic {ARB, STEAL} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [WW-1:0] wait_reg, wait_next;

  // Queue storage; only entries between head and head+count are meaningful,
  // so the arrays need no reset.
  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic          fifo_empty;
  logic          pipe_wr;
  logic          mdu_wr;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic [4:0]    wr_rd;
  logic [31:0]   wr_data;
  logic          stall;
  logic [31:0]   entry_mask [DEPTH];
  logic [31:0]   mask_or;

  assign fifo_empty  = (count_reg == '0);
  // Ready depends on the registered count only, so a same-cycle pop never
  // opens a slot early and there is no combinational path from the port.
  assign mdu_ready_o = (count_reg != FULL_COUNT);
  assign pipe_wr     = RegWriteW & (RdW != 5'd0);
  // x0 results are handshaken but never written or stored.
  assign mdu_wr      = mdu_valid_i & mdu_ready_o & (mdu_rd_i != 5'd0);

  // Port arbitration: steal cycle, then pipeline, then queue head, then bypass.
  always_comb begin
    wr_en   = 1'b0;
    wr_rd   = '0;
    wr_data = '0;
    stall   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    if (state_reg == STEAL) begin
      stall   = 1'b1;
      wr_en   = !fifo_empty;
      wr_rd   = rd_mem[head_reg];
      wr_data = data_mem[head_reg];
      pop     = !fifo_empty;
      push    = mdu_wr;
    end else if (pipe_wr) begin
      wr_en   = 1'b1;
      wr_rd   = RdW;
      wr_data = ResultW;
      push    = mdu_wr;
    end else if (!fifo_empty) begin
      wr_en   = 1'b1;
      wr_rd   = rd_mem[head_reg];
      wr_data = data_mem[head_reg];
      pop     = 1'b1;
      push    = mdu_wr;
    end else if (mdu_wr) begin
      // Empty queue and idle port: write the MDU result straight through.
      wr_en   = 1'b1;
      wr_rd   = mdu_rd_i;
      wr_data = mdu_data_i;
    end
  end

  // Occupancy, starvation counter and the decision to steal next cycle.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CW'(1);
    end
    wait_next = wait_reg;
    if (pop || fifo_empty) begin
      wait_next = '0;
    end else if (state_reg == ARB && wait_reg != WAIT_MAX) begin
      wait_next = wait_reg + WW'(1);
    end
    state_next = ARB;
    if (state_reg == ARB && count_next != '0 &&
        (count_next == FULL_COUNT || wait_next == WAIT_MAX)) begin
      state_next = STEAL;
    end
  end

  // Control registers; reset discards anything queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ARB;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      wait_reg  <= wait_next;
      if (push) begin
        tail_reg <= tail_reg + AW'(1);
      end
      if (pop) begin
        head_reg <= head_reg + AW'(1);
      end
    end
  end

  // Queue data write at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_reg]   <= mdu_rd_i;
      data_mem[tail_reg] <= mdu_data_i;
    end
  end

  // Per-slot one-hot rd, qualified by whether the slot is currently occupied.
  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [AW-1:0] offset;
    assign offset         = AW'(gi) - head_reg;
    assign entry_mask[gi] = ({1'b0, offset} < count_reg) ? (32'd1 << rd_mem[gi]) : 32'd0;
  end

  // OR of all occupied slots.
  always_comb begin
    mask_or = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mask_or = mask_or | entry_mask[i];
    end
  end

  assign pending_mask_o = mask_or & ~32'd1;
  // Write-port outputs are forced idle while reset is asserted.
  assign RegWriteRF     = wr_en & rst;
  assign RdRF           = rst ? wr_rd : 5'd0;
  assign WDRF           = rst ? wr_data : 32'd0;
  assign StallWB        = stall & rst;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus a randomized run checked
// against a queue-based reference model of the arbiter.
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        mdu_valid_i;
  logic [4:0]  mdu_rd_i;
  logic [31:0] mdu_data_i;
  logic        mdu_ready_o;
  logic        RegWriteRF;
  logic [4:0]  RdRF;
  logic [31:0] WDRF;
  logic        StallWB;
  logic [31:0] pending_mask_o;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t mq[$];
  int     m_wait;
  bit     m_steal;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .rst            (rst),
    .RegWriteW      (RegWriteW),
    .RdW            (RdW),
    .ResultW        (ResultW),
    .mdu_valid_i    (mdu_valid_i),
    .mdu_rd_i       (mdu_rd_i),
    .mdu_data_i     (mdu_data_i),
    .mdu_ready_o    (mdu_ready_o),
    .RegWriteRF     (RegWriteRF),
    .RdRF           (RdRF),
    .WDRF           (WDRF),
    .StallWB        (StallWB),
    .pending_mask_o (pending_mask_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    RegWriteW   = pw;
    RdW         = prd;
    ResultW     = pd;
    mdu_valid_i = mv;
    mdu_rd_i    = mrd;
    mdu_data_i  = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 5'd5, 32'h1111, 1'b1, 5'd7, 32'h2222);
    #2;
    total_cnt++;
    if (RegWriteRF !== 1'b0 || RdRF !== 5'd0 || WDRF !== 32'd0 || StallWB !== 1'b0 ||
        pending_mask_o !== 32'd0 || mdu_ready_o !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_outputs: got we=%b rd=%0d wd=%h stall=%b mask=%h ready=%b expected 0 0 0 0 0 ready=1",
               RegWriteRF, RdRF, WDRF, StallWB, pending_mask_o, mdu_ready_o);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if (RegWriteRF !== 1'b0 || pending_mask_o !== 32'd0 || mdu_ready_o !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_held: got we=%b mask=%h ready=%b expected we=0 mask=0 ready=1",
               RegWriteRF, pending_mask_o, mdu_ready_o);
    end else pass_cnt++;
    idle();
    @(negedge clk);
    rst = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_pipe_write();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    #1;
    total_cnt++;
    if (RegWriteRF !== 1'b1 || RdRF !== 5'd5 || WDRF !== 32'hDEADBEEF || StallWB !== 1'b0) begin
      fail_cnt++;
      $display("FAIL pipe_write: got we=%b rd=%0d wd=%h stall=%b expected we=1 rd=5 wd=deadbeef stall=0",
               RegWriteRF, RdRF, WDRF, StallWB);
    end else pass_cnt++;
    $display("pipe write rd=%0d data=%h", RdRF, WDRF);
    tick();
    idle();
  endtask

  task automatic test_bypass();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
    #1;
    total_cnt++;
    if (RegWriteRF !== 1'b1 || RdRF !== 5'd7 || WDRF !== 32'h1234 || mdu_ready_o !== 1'b1) begin
      fail_cnt++;
      $display("FAIL bypass_write: got we=%b rd=%0d wd=%h ready=%b expected we=1 rd=7 wd=1234 ready=1",
               RegWriteRF, RdRF, WDRF, mdu_ready_o);
    end else pass_cnt++;
    $display("bypass write rd=%0d data=%h", RdRF, WDRF);
    tick();
    idle();
    #1;
    total_cnt++;
    if (pending_mask_o !== 32'd0 || RegWriteRF !== 1'b0) begin
      fail_cnt++;
      $display("FAIL bypass_no_queue: got mask=%h we=%b expected mask=0 we=0", pending_mask_o, RegWriteRF);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_collision();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'hAA);
    #1;
    total_cnt++;
    if (RegWriteRF !== 1'b1 || RdRF !== 5'd3 || WDRF !== 32'h33) begin
      fail_cnt++;
      $display("FAIL collision_pipe_wins: got we=%b rd=%0d wd=%h expected we=1 rd=3 wd=33",
               RegWriteRF, RdRF, WDRF);
    end else pass_cnt++;
    $display("collision write rd=%0d, mdu rd9 queued", RdRF);
    tick();
    idle();
    #1;
    total_cnt++;
    if (pending_mask_o !== (32'd1 << 9) || RegWriteRF !== 1'b1 || RdRF !== 5'd9 || WDRF !== 32'hAA) begin
      fail_cnt++;
      $display("FAIL collision_drain: got mask=%h we=%b rd=%0d wd=%h expected mask=00000200 we=1 rd=9 wd=aa",
               pending_mask_o, RegWriteRF, RdRF, WDRF);
    end else pass_cnt++;
    $display("queued write rd=%0d data=%h", RdRF, WDRF);
    tick();
    total_cnt++;
    if (pending_mask_o !== 32'd0 || RegWriteRF !== 1'b0) begin
      fail_cnt++;
      $display("FAIL collision_mask_clear: got mask=%h we=%b expected mask=0 we=0", pending_mask_o, RegWriteRF);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_starve();
    int stalls;
    stalls = 0;
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd12, 32'h5555);
    #1;
    total_cnt++;
    if (RdRF !== 5'd1 || mdu_ready_o !== 1'b1) begin
      fail_cnt++;
      $display("FAIL starve_enqueue: got rd=%0d ready=%b expected rd=1 ready=1", RdRF, mdu_ready_o);
    end else pass_cnt++;
    tick();
    for (int c = 1; c <= 9; c++) begin
      drive(1'b1, 5'd4, 32'(c), 1'b0, 5'd0, 32'd0);
      #1;
      if (StallWB === 1'b1) stalls++;
      total_cnt++;
      if (c < 9) begin
        if (StallWB !== 1'b0 || RegWriteRF !== 1'b1 || RdRF !== 5'd4 || WDRF !== 32'(c) ||
            pending_mask_o !== (32'd1 << 12)) begin
          fail_cnt++;
          $display("FAIL starve_wait_c%0d: got stall=%b we=%b rd=%0d wd=%h mask=%h expected stall=0 we=1 rd=4 wd=%h mask=00001000",
                   c, StallWB, RegWriteRF, RdRF, WDRF, pending_mask_o, 32'(c));
        end else pass_cnt++;
      end else begin
        if (StallWB !== 1'b1 || RegWriteRF !== 1'b1 || RdRF !== 5'd12 || WDRF !== 32'h5555) begin
          fail_cnt++;
          $display("FAIL starve_steal: got stall=%b we=%b rd=%0d wd=%h expected stall=1 we=1 rd=12 wd=5555",
                   StallWB, RegWriteRF, RdRF, WDRF);
        end else pass_cnt++;
      end
      $display("starve cycle %0d write rd=%0d data=%h stall=%b", c, RdRF, WDRF, StallWB);
      tick();
    end
    drive(1'b1, 5'd4, 32'd9, 1'b0, 5'd0, 32'd0);
    #1;
    if (StallWB === 1'b1) stalls++;
    total_cnt++;
    if (StallWB !== 1'b0 || RdRF !== 5'd4 || WDRF !== 32'd9 || pending_mask_o !== 32'd0 || stalls != 1) begin
      fail_cnt++;
      $display("FAIL starve_retry: got stall=%b rd=%0d wd=%h mask=%h stalls=%0d expected stall=0 rd=4 wd=9 mask=0 stalls=1",
               StallWB, RdRF, WDRF, pending_mask_o, stalls);
    end else pass_cnt++;
    $display("retried pipe write rd=%0d data=%h", RdRF, WDRF);
    tick();
    idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd2, 32'(i), 1'b1, 5'(10 + i), 32'(32'hA0 + i));
      #1;
      total_cnt++;
      if (mdu_ready_o !== 1'b1 || RdRF !== 5'd2 || StallWB !== 1'b0) begin
        fail_cnt++;
        $display("FAIL full_fill_%0d: got ready=%b rd=%0d stall=%b expected ready=1 rd=2 stall=0",
                 i, mdu_ready_o, RdRF, StallWB);
      end else pass_cnt++;
      $display("fill %0d: pipe rd=%0d, mdu rd=%0d accepted", i, RdRF, 10 + i);
      tick();
    end
    drive(1'b1, 5'd2, 32'd4, 1'b1, 5'd14, 32'hA4);
    #1;
    total_cnt++;
    if (mdu_ready_o !== 1'b0 || StallWB !== 1'b1 || RdRF !== 5'd10 || WDRF !== 32'hA0) begin
      fail_cnt++;
      $display("FAIL full_steal: got ready=%b stall=%b rd=%0d wd=%h expected ready=0 stall=1 rd=10 wd=a0",
               mdu_ready_o, StallWB, RdRF, WDRF);
    end else pass_cnt++;
    $display("full steal write rd=%0d data=%h", RdRF, WDRF);
    tick();
    drive(1'b1, 5'd2, 32'd4, 1'b0, 5'd0, 32'd0);
    #1;
    total_cnt++;
    if (mdu_ready_o !== 1'b1 || StallWB !== 1'b0 || RdRF !== 5'd2 ||
        pending_mask_o !== ((32'd1 << 11) | (32'd1 << 12) | (32'd1 << 13))) begin
      fail_cnt++;
      $display("FAIL full_after_steal: got ready=%b stall=%b rd=%0d mask=%h expected ready=1 stall=0 rd=2 mask=00003800",
               mdu_ready_o, StallWB, RdRF, pending_mask_o);
    end else pass_cnt++;
    tick();
    for (int j = 1; j <= 3; j++) begin
      idle();
      #1;
      total_cnt++;
      if (RegWriteRF !== 1'b1 || RdRF !== 5'(10 + j) || WDRF !== 32'(32'hA0 + j)) begin
        fail_cnt++;
        $display("FAIL full_drain_%0d: got we=%b rd=%0d wd=%h expected we=1 rd=%0d wd=%h",
                 j, RegWriteRF, RdRF, WDRF, 10 + j, 32'hA0 + j);
      end else pass_cnt++;
      $display("drain write rd=%0d data=%h", RdRF, WDRF);
      tick();
    end
    #1;
    total_cnt++;
    if (RegWriteRF !== 1'b0 || pending_mask_o !== 32'd0) begin
      fail_cnt++;
      $display("FAIL full_empty: got we=%b mask=%h expected we=0 mask=0", RegWriteRF, pending_mask_o);
    end else pass_cnt++;
    tick();
  endtask

  task automatic test_x0_and_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
    #1;
    total_cnt++;
    if (mdu_ready_o !== 1'b1 || RegWriteRF !== 1'b0) begin
      fail_cnt++;
      $display("FAIL x0_accept: got ready=%b we=%b expected ready=1 we=0", mdu_ready_o, RegWriteRF);
    end else pass_cnt++;
    $display("mdu x0 result accepted and dropped");
    tick();
    idle();
    #1;
    total_cnt++;
    if (pending_mask_o !== 32'd0 || RegWriteRF !== 1'b0) begin
      fail_cnt++;
      $display("FAIL x0_not_queued: got mask=%h we=%b expected mask=0 we=0", pending_mask_o, RegWriteRF);
    end else pass_cnt++;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd3, 32'(i), 1'b1, 5'(20 + i), 32'(32'hB0 + i));
      tick();
    end
    drive(1'b1, 5'd3, 32'd9, 1'b0, 5'd0, 32'd0);
    #1;
    total_cnt++;
    if (pending_mask_o !== ((32'd1 << 20) | (32'd1 << 21) | (32'd1 << 22))) begin
      fail_cnt++;
      $display("FAIL queued_three_mask: got mask=%h expected mask=00700000", pending_mask_o);
    end else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (pending_mask_o !== 32'd0 || mdu_ready_o !== 1'b1 || RegWriteRF !== 1'b0) begin
      fail_cnt++;
      $display("FAIL midop_reset: got mask=%h ready=%b we=%b expected mask=0 ready=1 we=0",
               pending_mask_o, mdu_ready_o, RegWriteRF);
    end else pass_cnt++;
    $display("reset pulsed with 3 entries queued");
    idle();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      total_cnt++;
      if (RegWriteRF !== 1'b0 || pending_mask_o !== 32'd0) begin
        fail_cnt++;
        $display("FAIL post_reset_quiet_%0d: got we=%b rd=%0d mask=%h expected we=0 mask=0",
                 k, RegWriteRF, RdRF, pending_mask_o);
      end else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_random();
    logic        pw, mv;
    logic [4:0]  prd, mrd;
    logic [31:0] pd, md;
    bit          e_ready, e_we, e_stall, e_pop, e_bypass, e_mwr, e_pwr;
    logic [4:0]  e_rd;
    logic [31:0] e_wd, e_mask;
    entry_t      ent;
    int          old_size;

    rst = 1'b0;
    idle();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    mq.delete();
    m_wait  = 0;
    m_steal = 1'b0;

    for (int n = 0; n < 1000; n++) begin
      pw  = ($urandom_range(0, 9) < 7);
      prd = 5'($urandom_range(0, 31));
      pd  = $urandom;
      mv  = ($urandom_range(0, 9) < 4);
      mrd = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      md  = $urandom;
      drive(pw, prd, pd, mv, mrd, md);

      e_ready  = (mq.size() < DEPTH);
      e_mwr    = mv && e_ready && (mrd != 5'd0);
      e_pwr    = pw && (prd != 5'd0);
      e_we     = 1'b0;
      e_stall  = 1'b0;
      e_pop    = 1'b0;
      e_bypass = 1'b0;
      e_rd     = 5'd0;
      e_wd     = 32'd0;
      if (m_steal) begin
        e_we = 1'b1; e_stall = 1'b1; e_pop = 1'b1;
        e_rd = mq[0].rd; e_wd = mq[0].data;
      end else if (e_pwr) begin
        e_we = 1'b1; e_rd = prd; e_wd = pd;
      end else if (mq.size() > 0) begin
        e_we = 1'b1; e_pop = 1'b1;
        e_rd = mq[0].rd; e_wd = mq[0].data;
      end else if (e_mwr) begin
        e_we = 1'b1; e_bypass = 1'b1; e_rd = mrd; e_wd = md;
      end
      e_mask = 32'd0;
      foreach (mq[q]) e_mask = e_mask | (32'd1 << mq[q].rd);

      #1;
      total_cnt++;
      if (RegWriteRF !== e_we || StallWB !== e_stall || mdu_ready_o !== e_ready ||
          pending_mask_o !== e_mask || (e_we && (RdRF !== e_rd || WDRF !== e_wd))) begin
        fail_cnt++;
        $display("FAIL random_cyc%0d: got we=%b rd=%0d wd=%h stall=%b ready=%b mask=%h expected we=%b rd=%0d wd=%h stall=%b ready=%b mask=%h",
                 n, RegWriteRF, RdRF, WDRF, StallWB, mdu_ready_o, pending_mask_o,
                 e_we, e_rd, e_wd, e_stall, e_ready, e_mask);
      end else pass_cnt++;
      if (e_we) $display("random cyc %0d write rd=%0d data=%h stall=%b", n, e_rd, e_wd, e_stall);
      tick();

      old_size = mq.size();
      if (e_pop) ent = mq.pop_front();
      if (e_mwr && !e_bypass) begin
        ent.rd   = mrd;
        ent.data = md;
        mq.push_back(ent);
      end
      if (e_pop || old_size == 0) m_wait = 0;
      else if (!m_steal && m_wait < LIMIT) m_wait = m_wait + 1;
      m_steal = !m_steal && (mq.size() > 0) && (mq.size() == DEPTH || m_wait == LIMIT);
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_pipe_write();
    test_bypass();
    test_collision();
    test_starve();
    test_full();
    test_x0_and_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
